// File: rtl/cam_stats_pkg.sv
// Shared types and default widths for the grayscale statistics path.
// The default counter width is sized to hold one full 800x480 frame.
package cam_stats_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_HIST   = 2'd2,
    MODE_CDF    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2
  } state_e;

  localparam int FRAME_W   = 800;
  localparam int FRAME_H   = 480;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_BIN_W = 8;
  localparam int DEF_CNT_W = $clog2(FRAME_W * FRAME_H + 1);

endpackage

// File: rtl/hist_bank.sv
// Flop-array histogram accumulator: one increment and one scan read/clear port.
// Define HIST_SATURATE_EN to make counts stick at all-ones instead of wrapping.
module hist_bank
  import cam_stats_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [BIN_W-1:0] inc_idx,
  input  logic             scan_en,
  input  logic [BIN_W-1:0] scan_idx,
  output logic [CNT_W-1:0] scan_cnt
);

  localparam int NBINS = 1 << BIN_W;

  logic [CNT_W-1:0] cnt [NBINS];
  logic [CNT_W-1:0] inc_cur;
  logic [CNT_W-1:0] inc_next;

  assign scan_cnt = cnt[scan_idx];
  assign inc_cur  = cnt[inc_idx];

`ifdef HIST_SATURATE_EN
  assign inc_next = (&inc_cur) ? inc_cur : inc_cur + CNT_W'(1);
`else
  assign inc_next = inc_cur + CNT_W'(1);
`endif

  // Scan and increment never overlap in practice; scan wins if they ever do.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBINS; i++) cnt[i] <= '0;
    end else if (scan_en) begin
      cnt[scan_idx] <= '0;
    end else if (inc_en) begin
      cnt[inc_idx] <= inc_next;
    end
  end

endmodule

// File: rtl/hist_stats_engine.sv
// Per-frame grayscale histogram/CDF engine with 1-cycle pixel remap.
// Define HIST_SATURATE_EN to saturate bin counts and the running sum.
//
// state    | meaning
// ST_IDLE  | waiting for a rising edge of iFval
// ST_ACCUM | frame streaming, counting pixels into acc
// ST_SCAN  | copying acc into display tables, one bin per cycle
module hist_stats_engine
  import cam_stats_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int BIN_W      = DEF_BIN_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HIST_SHIFT = CNT_W - PIX_W
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iFval,
  input  logic             iDval,
  input  logic [PIX_W-1:0] iPix,
  input  logic [1:0]       iMode,
  input  logic [PIX_W-1:0] iThresh,
  output logic [PIX_W-1:0] oPix,
  output logic             oDval,
  output logic             oStatsValid,
  output logic             oOverrun
);

  localparam int NBINS  = 1 << BIN_W;
  localparam int BIN_SH = PIX_W - BIN_W;

  state_e           state;
  logic             fval_q;
  logic [BIN_W-1:0] k;
  logic [CNT_W-1:0] sum;
  logic [CNT_W-1:0] sum_next;
  logic [CNT_W-1:0] acc_k;
  logic [CNT_W-1:0] dhist [NBINS];
  logic [CNT_W-1:0] dcdf  [NBINS];

  logic             pix_in;
  logic             fval_rise;
  logic             fval_fall;
  logic             acc_inc;
  logic [BIN_W-1:0] bin;
  logic [CNT_W-1:0] lut_v;
  logic [PIX_W-1:0] pix_map;

  assign pix_in    = iFval & iDval;
  assign fval_rise = iFval & ~fval_q;
  assign fval_fall = ~iFval & fval_q;
  assign bin       = BIN_W'(iPix >> BIN_SH);
  // The first pixel of a frame lands while the FSM is still in IDLE.
  assign acc_inc   = pix_in & ((state == ST_ACCUM) | ((state == ST_IDLE) & fval_rise));

  hist_bank #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk      (iClk),
    .rst_n    (iRst_n),
    .inc_en   (acc_inc),
    .inc_idx  (bin),
    .scan_en  (state == ST_SCAN),
    .scan_idx (k),
    .scan_cnt (acc_k)
  );

`ifdef HIST_SATURATE_EN
  logic [CNT_W:0] sum_ext;
  assign sum_ext  = {1'b0, sum} + {1'b0, acc_k};
  assign sum_next = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
`else
  assign sum_next = sum + acc_k;
`endif

  always_comb begin
    pix_map = '0;
    lut_v   = '0;
    case (mode_e'(iMode))
      MODE_PASS:   pix_map = iPix;
      MODE_THRESH: pix_map = (iPix >= iThresh) ? '1 : '0;
      MODE_HIST, MODE_CDF: begin
        lut_v = ((mode_e'(iMode) == MODE_HIST) ? dhist[bin] : dcdf[bin]) >> HIST_SHIFT;
        if (!oStatsValid || state == ST_SCAN) pix_map = '0;
        else if ((lut_v >> PIX_W) != '0)      pix_map = '1;
        else                                  pix_map = PIX_W'(lut_v);
      end
      default: pix_map = iPix;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state       <= ST_IDLE;
      fval_q      <= 1'b0;
      k           <= '0;
      sum         <= '0;
      oPix        <= '0;
      oDval       <= 1'b0;
      oStatsValid <= 1'b0;
      oOverrun    <= 1'b0;
      for (int i = 0; i < NBINS; i++) begin
        dhist[i] <= '0;
        dcdf[i]  <= '0;
      end
    end else begin
      fval_q   <= iFval;
      oDval    <= pix_in;
      oPix     <= pix_map;
      oOverrun <= pix_in & (state == ST_SCAN);
      case (state)
        ST_IDLE: begin
          if (fval_rise) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (fval_fall) begin
            state <= ST_SCAN;
            k     <= '0;
            sum   <= '0;
          end
        end
        ST_SCAN: begin
          dhist[k] <= acc_k;
          dcdf[k]  <= sum_next;
          sum      <= sum_next;
          k        <= k + 1'b1;
          if (&k) begin
            // A frame that started mid-sweep continues straight into ACCUM.
            state       <= iFval ? ST_ACCUM : ST_IDLE;
            sum         <= '0;
            oStatsValid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
